pulse_len_meter: RTL

PULSE_LEN_METER -- requirements
Module: pulse_len_meter

---
 rtl/pulse_len_meter_pkg.sv | 23 ++
 rtl/pulse_len_meter_sat_counter.sv | 49 ++++
 rtl/pulse_len_meter.sv | 162 ++++++++++++++++
 3 files changed

// File: rtl/pulse_len_meter_pkg.sv
// Shared definitions for the pulse length meter.
// Holds the FSM state encoding, the default counter width and a helper
// that gives the all-ones (saturation) value for a given width.
package pulse_len_meter_pkg;

  // Default width of the length counter and of len.
  localparam int unsigned PLM_W = 4;

  // Measurement / handshake states.
  typedef enum logic [2:0] {
    S_SYNC  = 3'd0,  // wait for in low so a pulse already in progress is skipped
    S_IDLE  = 3'd1,  // armed, waiting for a rising pulse
    S_COUNT = 3'd2,  // counting high cycles
    S_ACK   = 3'd3,  // dav_ low, waiting for consumer acknowledge (rfd low)
    S_REL   = 3'd4   // dav_ high again, waiting for consumer release (rfd high)
  } plm_state_e;

  // Largest value representable in w bits, returned in 32 bits.
  function automatic int unsigned plm_max(input int unsigned w);
    plm_max = (32'd1 << w) - 32'd1;
  endfunction

endpackage : pulse_len_meter_pkg

// File: rtl/pulse_len_meter_sat_counter.sv
// Saturating up-counter used to measure the high-run length.
// Ports:
//   clock  - system clock, rising edge
//   reset_ - asynchronous active-low reset, clears the count
//   clr    - synchronous clear; with inc also set the count loads 1
//   inc    - increment request, ignored once the count is all ones
//   q      - current count (registered)
//   sat    - high while q is at its maximum value
module sat_counter
  import pulse_len_meter_pkg::*;
#(
  parameter int unsigned W = PLM_W
) (
  input  logic         clock,
  input  logic         reset_,
  input  logic         clr,
  input  logic         inc,
  output logic [W-1:0] q,
  output logic         sat
);

  localparam logic [W-1:0] MAX_V = {W{1'b1}};

  logic [W-1:0] q_q;
  logic [W-1:0] q_d;

  // Next count: clear (optionally straight to 1), else increment without wrap.
  always_comb begin
    q_d = q_q;
    if (clr) begin
      q_d = inc ? W'(1) : '0;
    end else if (inc && (q_q != MAX_V)) begin
      q_d = q_q + W'(1);
    end
  end

  // Count register.
  always_ff @(posedge clock or negedge reset_) begin
    if (!reset_) begin
      q_q <= '0;
    end else begin
      q_q <= q_d;
    end
  end

  assign q   = q_q;
  assign sat = (q_q == MAX_V);

endmodule : sat_counter

// File: rtl/pulse_len_meter.sv
// Pulse length meter: measures the number of clock edges for which in was
// sampled high, then hands the result to a consumer over a four-phase
// dav_/rfd handshake (dav_ fall -> rfd fall -> dav_ rise -> rfd rise).
// Pulses arriving during the handshake are dropped whole: after release the
// FSM re-synchronises on in low before it will start a new measurement.
// Optional feature: define PULSE_LEN_OVF_EN to add the ovf output, which
// flags that the counter saturated during the reported run.
// Ports:
//   clock  - system clock, rising edge
//   reset_ - asynchronous active-low reset
//   in     - pulse train to measure
//   rfd    - consumer ready-for-data; 0 acknowledges, 1 means ready
//   dav_   - active-low data-available strobe (registered)
//   len    - measured high-run length, stable while dav_ is 0 (registered)
//   ovf    - saturation flag, held like len (PULSE_LEN_OVF_EN only)
module pulse_len_meter
  import pulse_len_meter_pkg::*;
#(
  parameter int unsigned W = PLM_W
) (
  input  logic         clock,
  input  logic         reset_,
  input  logic         in,
  input  logic         rfd,
  output logic         dav_,
  output logic [W-1:0] len
`ifdef PULSE_LEN_OVF_EN
  ,
  output logic         ovf
`endif
);

  plm_state_e   state_q;
  plm_state_e   state_d;
  logic [W-1:0] len_q;
  logic [W-1:0] len_d;
  logic         dav_q;
  logic         dav_d;

  logic         cnt_clr;
  logic         cnt_inc;
  logic [W-1:0] cnt_q;
  logic         cnt_sat;
  logic         cap_c;

  // Run-length counter.
  sat_counter #(
    .W (W)
  ) u_cnt (
    .clock  (clock),
    .reset_ (reset_),
    .clr    (cnt_clr),
    .inc    (cnt_inc),
    .q      (cnt_q),
    .sat    (cnt_sat)
  );

  // Next-state, counter control and output register next values.
  always_comb begin
    state_d = state_q;
    len_d   = len_q;
    dav_d   = dav_q;
    cnt_clr = 1'b0;
    cnt_inc = 1'b0;
    cap_c   = 1'b0;

    unique case (state_q)
      S_SYNC: begin
        if (!in) begin
          state_d = S_IDLE;
        end
      end

      S_IDLE: begin
        // First high sample counts as 1.
        if (in) begin
          cnt_clr = 1'b1;
          cnt_inc = 1'b1;
          state_d = S_COUNT;
        end
      end

      S_COUNT: begin
        if (in) begin
          // Counter also guards saturation; gating here avoids useless toggles.
          cnt_inc = !cnt_sat;
        end else begin
          // Capture on the same edge that sees in low, and clear for the next run.
          cap_c   = 1'b1;
          len_d   = cnt_q;
          dav_d   = 1'b0;
          cnt_clr = 1'b1;
          state_d = S_ACK;
        end
      end

      S_ACK: begin
        // Entered with dav_ already low, so dav_ stays low a full cycle
        // even when rfd is low on entry.
        if (!rfd) begin
          dav_d   = 1'b1;
          state_d = S_REL;
        end
      end

      S_REL: begin
        if (rfd) begin
          state_d = S_SYNC;
        end
      end

      default: begin
        dav_d   = 1'b1;
        state_d = S_SYNC;
      end
    endcase
  end

  // State and output registers.
  always_ff @(posedge clock or negedge reset_) begin
    if (!reset_) begin
      state_q <= S_SYNC;
      len_q   <= '0;
      dav_q   <= 1'b1;
    end else begin
      state_q <= state_d;
      len_q   <= len_d;
      dav_q   <= dav_d;
    end
  end

  assign dav_ = dav_q;
  assign len  = len_q;

`ifdef PULSE_LEN_OVF_EN
  logic ovf_q;
  logic ovf_d;

  // Saturation flag is loaded alongside len and held with it.
  always_comb begin
    ovf_d = ovf_q;
    if (cap_c) begin
      ovf_d = cnt_sat;
    end
  end

  always_ff @(posedge clock or negedge reset_) begin
    if (!reset_) begin
      ovf_q <= 1'b0;
    end else begin
      ovf_q <= ovf_d;
    end
  end

  assign ovf = ovf_q;
`else
  // Capture strobe only feeds the optional flag.
  logic unused_cap;
  assign unused_cap = cap_c;
`endif

endmodule : pulse_len_meter
